// File: rtl/cordic_polar_collector_pkg.sv
// Shared CORDIC constants and result types used by the polar collector and its FIFO.
package cordic_pkg;

  localparam int CORDIC_LAT = 9;
  localparam int ANGLE_W    = 16;

  localparam logic [ANGLE_W-1:0] ANGLE_180 = 16'h8000;
  localparam logic [ANGLE_W-1:0] ANGLE_90  = 16'h4000;

  typedef struct packed {
    logic [15:0] norm;
    logic [15:0] angle;
  } polar_t;

  // Occupancy counters need one bit beyond the address width to tell full from empty.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cordic_polar_collector_if.sv
// CORDIC result input, output stream and status/control signals of the polar collector.
interface cordic_polar_collector_if #(
  parameter int W     = 16,
  parameter int DEPTH = 8
);
  import cordic_pkg::*;

  localparam int LW = level_w(DEPTH);

  logic          in_valid;
  logic [W-1:0]  norm;
  logic [W-1:0]  inclination;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_norm;
  logic [W-1:0]  out_angle;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          ovf_clr;
  logic [W-1:0]  peak_norm;
  logic          peak_clr;

  modport slave (
    input  in_valid, norm, inclination, out_ready, ovf_clr, peak_clr,
    output out_valid, out_norm, out_angle, fifo_level, overflow, peak_norm
  );

  modport master (
    output in_valid, norm, inclination, out_ready, ovf_clr, peak_clr,
    input  out_valid, out_norm, out_angle, fifo_level, overflow, peak_norm
  );

endinterface

// File: rtl/cordic_polar_collector_fifo.sv
// First-word fall-through synchronous FIFO; head entry is read combinationally from storage.
module sync_fifo_fwft #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_cnt;
  logic [AW:0]      r_rd_cnt;
  logic [AW:0]      w_level;
  logic             w_full;
  logic             w_empty;
  logic             w_rd;
  logic             w_wr;

  assign w_level = r_wr_cnt - r_rd_cnt;
  assign w_empty = (w_level == '0);
  assign w_full  = (w_level == (AW+1)'(DEPTH));
  assign w_rd    = i_pop & ~w_empty;
  // A write into a full FIFO is safe when the head is popped on the same edge.
  assign w_wr    = i_push & (~w_full | w_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_wr) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_rd) r_rd_cnt <= r_rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_cnt[AW-1:0]] <= i_data;
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rd_cnt[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_level = w_level;

endmodule

// File: rtl/cordic_polar_collector.sv
// Aligns the sample strobe to CORDIC latency, buffers {norm, angle} results and tracks
// overflow and peak norm.
module cordic_polar_collector
  import cordic_pkg::*;
#(
  parameter int CORDIC_LAT = cordic_pkg::CORDIC_LAT,
  parameter int DEPTH      = 8,
  parameter int W          = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  cordic_polar_collector_if.slave  bus
);

  localparam int LW = level_w(DEPTH);

  logic [CORDIC_LAT-1:0] r_vld_sr;
  logic                  r_overflow;
  logic [W-1:0]          r_peak;
  logic                  w_cap;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push_ok;
  logic                  w_drop;
  logic [2*W-1:0]        w_head;
  logic [LW-1:0]         w_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vld_sr <= '0;
    else        r_vld_sr <= {r_vld_sr[CORDIC_LAT-2:0], bus.in_valid};
  end

  assign w_cap     = r_vld_sr[CORDIC_LAT-1];
  assign w_pop     = ~w_empty & bus.out_ready;
  assign w_push_ok = w_cap & (~w_full | w_pop);
  assign w_drop    = w_cap & w_full & ~w_pop;

  sync_fifo_fwft #(
    .WIDTH (2*W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_ok),
    .i_data  ({bus.norm, bus.inclination}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Set wins over clear so a drop is never hidden by a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_overflow <= 1'b0;
    else if (w_drop)   r_overflow <= 1'b1;
    else if (bus.ovf_clr) r_overflow <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak <= '0;
    end else if (w_push_ok) begin
      if (bus.peak_clr || (bus.norm > r_peak)) r_peak <= bus.norm;
    end else if (bus.peak_clr) begin
      r_peak <= '0;
    end
  end

  assign bus.out_valid  = ~w_empty;
  assign bus.out_norm   = w_head[2*W-1:W];
  assign bus.out_angle  = w_head[W-1:0];
  assign bus.fifo_level = w_level;
  assign bus.overflow   = r_overflow;
  assign bus.peak_norm  = r_peak;

endmodule

// File: tb/tb_cordic_polar_collector.sv
// Scoreboard bench for cordic_polar_collector: directed scenarios plus randomized traffic.
module tb_cordic_polar_collector;
  import cordic_pkg::*;

  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int LAT   = CORDIC_LAT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cordic_polar_collector_if #(.W(W), .DEPTH(DEPTH)) bus ();

  cordic_polar_collector #(
    .CORDIC_LAT (LAT),
    .DEPTH      (DEPTH),
    .W          (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a sample strobed at cycle k delivers the norm/angle present LAT
  // cycles later into a DEPTH-entry queue; pop happens whenever the queue is non-empty
  // and the consumer is ready.
  int          mcyc    = 0;
  int          pend_q[$];
  polar_t      exp_q[$];
  int          m_level = 0;
  logic        m_ovf   = 1'b0;
  logic [W-1:0] m_peak = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q.delete();
      exp_q.delete();
      m_level = 0;
      m_ovf   = 1'b0;
      m_peak  = '0;
    end else begin : model_step
      bit cap, pop, acc;
      polar_t p;
      cap = (pend_q.size() > 0) && (pend_q[0] == mcyc);
      if (cap) void'(pend_q.pop_front());
      pop = (m_level > 0) && bus.out_ready;
      acc = cap && ((m_level < DEPTH) || pop);
      if (acc) begin
        p.norm  = bus.norm;
        p.angle = bus.inclination;
        exp_q.push_back(p);
      end
      m_level = m_level - int'(pop) + int'(acc);
      if (cap && !acc)   m_ovf = 1'b1;
      else if (bus.ovf_clr) m_ovf = 1'b0;
      if (acc) m_peak = bus.peak_clr ? bus.norm : ((bus.norm > m_peak) ? bus.norm : m_peak);
      else if (bus.peak_clr) m_peak = '0;
      if (bus.in_valid) pend_q.push_back(mcyc + LAT);
      mcyc++;
    end
  end

  // Monitor: compares DUT outputs against the model mid-cycle.
  logic         hold = 1'b0;
  logic [W-1:0] hold_n, hold_a;
  logic [W-1:0] last_pop_norm = '0;

  always @(negedge clk) begin
    chk("out_valid",  32'(bus.out_valid),  32'(m_level > 0));
    chk("fifo_level", 32'(bus.fifo_level), 32'(m_level));
    chk("overflow",   32'(bus.overflow),   32'(m_ovf));
    chk("peak_norm",  32'(bus.peak_norm),  32'(m_peak));
    if (hold && bus.out_valid) begin
      chk("stable_norm",  32'(bus.out_norm),  32'(hold_n));
      chk("stable_angle", 32'(bus.out_angle), 32'(hold_a));
    end
    if (bus.out_valid && exp_q.size() > 0) begin
      chk("out_norm",  32'(bus.out_norm),  32'(exp_q[0].norm));
      chk("out_angle", 32'(bus.out_angle), 32'(exp_q[0].angle));
      if (bus.out_ready) begin
        last_pop_norm = exp_q[0].norm;
        void'(exp_q.pop_front());
      end
    end
    hold   = bus.out_valid && !bus.out_ready;
    hold_n = bus.out_norm;
    hold_a = bus.out_angle;
  end

  // Driver: per-cycle data tables let a test line up norm/ready/peak_clr with a capture.
  int           tcyc    = 0;
  logic         rdy_def = 1'b1;
  logic [W-1:0] dn[int];
  logic [W-1:0] da[int];
  bit           dpclr[int];
  bit           drdy[int];

  task automatic tick();
    @(posedge clk);
    #1;
    tcyc++;
    bus.in_valid    = 1'b0;
    bus.ovf_clr     = 1'b0;
    bus.norm        = dn.exists(tcyc) ? dn[tcyc] : 16'($urandom);
    bus.inclination = da.exists(tcyc) ? da[tcyc] : 16'($urandom);
    bus.peak_clr    = dpclr.exists(tcyc) ? 1'b1 : 1'b0;
    bus.out_ready   = drdy.exists(tcyc) ? drdy[tcyc] : rdy_def;
  endtask

  task automatic issue(input logic [W-1:0] n, input logic [W-1:0] a, input bit pclr = 1'b0);
    bus.in_valid = 1'b1;
    dn[tcyc+LAT] = n;
    da[tcyc+LAT] = a;
    if (pclr) dpclr[tcyc+LAT] = 1'b1;
  endtask

  task automatic drain(input string name);
    rdy_def = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.fifo_level == '0) break;
    end
    chk(name, 32'(bus.fifo_level), 32'd0);
  endtask

  int thr;

  initial begin
    bus.in_valid    = 1'b0;
    bus.norm        = '0;
    bus.inclination = '0;
    bus.out_ready   = 1'b1;
    bus.ovf_clr     = 1'b0;
    bus.peak_clr    = 1'b0;

    repeat (2) tick();
    chk("rst_level",     32'(bus.fifo_level), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid),  32'd0);
    chk("rst_out_norm",  32'(bus.out_norm),   32'd0);
    chk("rst_out_angle", 32'(bus.out_angle),  32'd0);
    chk("rst_overflow",  32'(bus.overflow),   32'd0);
    chk("rst_peak",      32'(bus.peak_norm),  32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Alignment: strobe at cycle 0, data at cycle LAT, visible at LAT+1.
    tick();
    issue(16'd1000, 16'h2000);
    repeat (LAT) tick();
    chk("align_early", 32'(bus.out_valid), 32'd0);
    tick();
    chk("align_valid", 32'(bus.out_valid), 32'd1);
    chk("align_norm",  32'(bus.out_norm),  32'd1000);
    chk("align_angle", 32'(bus.out_angle), 32'h2000);
    drain("align_drain");

    // Burst of 8 into a stalled consumer, then a 9th that must be dropped.
    tick();
    bus.peak_clr = 1'b1;
    bus.ovf_clr  = 1'b1;
    rdy_def = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      issue(16'(i), ANGLE_90);
    end
    repeat (LAT + 1) tick();
    chk("burst_level", 32'(bus.fifo_level), 32'd8);
    chk("burst_ovf",   32'(bus.overflow),   32'd1);
    chk("burst_peak",  32'(bus.peak_norm),  32'd8);
    drain("burst_drain");
    chk("burst_last", 32'(last_pop_norm), 32'd8);

    // Full FIFO with simultaneous push and pop.
    tick();
    bus.ovf_clr = 1'b1;
    rdy_def = 1'b0;
    for (int i = 11; i <= 18; i++) begin
      tick();
      issue(16'(i), ANGLE_180);
    end
    tick();
    issue(16'd99, 16'h1234);
    drdy[tcyc+LAT] = 1'b1;
    repeat (LAT + 1) tick();
    chk("fullpp_level", 32'(bus.fifo_level), 32'd8);
    chk("fullpp_ovf",   32'(bus.overflow),   32'd0);
    drain("fullpp_drain");
    chk("fullpp_last", 32'(last_pop_norm), 32'd99);

    // Peak tracking with an unsigned compare, then clear coinciding with a push.
    tick();
    bus.peak_clr = 1'b1;
    rdy_def = 1'b1;
    tick(); issue(16'd500,   16'h0100);
    tick(); issue(16'd40000, 16'h0200);
    tick(); issue(16'd300,   16'h0300);
    repeat (LAT + 3) tick();
    chk("peak_max", 32'(bus.peak_norm), 32'd40000);
    tick(); issue(16'd7, ANGLE_90, 1'b1);
    repeat (LAT + 1) tick();
    chk("peak_clr_push", 32'(bus.peak_norm), 32'd7);

    // Reset with 4 entries buffered and 3 samples still in the pipeline.
    rdy_def = 1'b0;
    for (int i = 21; i <= 24; i++) begin
      tick();
      issue(16'(i), 16'h0042);
    end
    repeat (LAT + 1) tick();
    chk("prerst_level", 32'(bus.fifo_level), 32'd4);
    for (int i = 31; i <= 33; i++) begin
      tick();
      issue(16'(i), 16'h0043);
    end
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_level", 32'(bus.fifo_level), 32'd0);
    chk("midrst_valid", 32'(bus.out_valid),  32'd0);
    chk("midrst_norm",  32'(bus.out_norm),   32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (LAT + 6) tick();
    chk("postrst_level", 32'(bus.fifo_level), 32'd0);
    chk("postrst_valid", 32'(bus.out_valid),  32'd0);

    // Randomized traffic with a varying consumer duty cycle.
    thr = 50;
    for (int c = 0; c < 10000; c++) begin
      tick();
      if (c % 1000 == 0) thr = int'($urandom_range(15, 95));
      bus.in_valid  = ($urandom_range(0, 99) < 55);
      bus.out_ready = ($urandom_range(0, 99) < thr);
      bus.ovf_clr   = ($urandom_range(0, 49) == 0);
      bus.peak_clr  = ($urandom_range(0, 199) == 0);
    end
    repeat (LAT + 1) tick();
    drain("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
